fir_mac: RTL

FIR_MAC -- requirements
Module: fir_mac

---
 rtl/fir_mac.sv | 67 ++++++
 1 files changed

// File: rtl/fir_mac.sv
// Sequential FIR filter: one multiply-accumulate per cycle over an NTAPS-deep
// delay line, with coefficients read from an external combinational ROM.
module fir_mac #(
    parameter int NTAPS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     smpl_vld,
    input  logic [15:0]              smpl,
    input  logic [15:0]              coeff,
    output logic [$clog2(NTAPS)-1:0] coeff_addr,
    output logic                     busy,
    output logic                     m_vld,
    output logic [18:0]              m_28to10
);

    localparam int AW = $clog2(NTAPS);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t             state;
    logic signed [15:0] x [NTAPS];
    logic        [30:0] acc;
    logic      [AW-1:0] idx;
    logic signed [30:0] prod;

    // Product is formed directly at 31 bits, which is exactly the mod-2^31 wrap.
    assign prod       = x[idx] * $signed(coeff);
    assign busy       = (state != IDLE);
    assign coeff_addr = (state == MAC) ? idx : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            for (int unsigned k = 0; k < NTAPS; k++) x[k] <= '0;
            acc      <= '0;
            idx      <= '0;
            m_vld    <= 1'b0;
            m_28to10 <= '0;
        end else begin
            m_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (smpl_vld) begin
                        x[0] <= smpl;
                        for (int unsigned k = 1; k < NTAPS; k++) x[k] <= x[k-1];
                        acc   <= '0;
                        idx   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + prod;
                    if (idx == AW'(NTAPS - 1)) state <= DONE;
                    else                       idx   <= idx + AW'(1);
                end
                DONE: begin
                    m_28to10 <= acc[28:10];
                    m_vld    <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
